// File: rtl/spi_reg_bridge.sv
// SPI word protocol layer: decodes command/data words into a req/ack register bus.
// Optional feature: define SPI_BRIDGE_AUTOINC_EN for address-incrementing bursts.
module spi_reg_bridge #(
   parameter int unsigned K_DWIDTH = 16,
   parameter int unsigned K_AWIDTH = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [K_DWIDTH-1:0] i_rx_data,
   input  logic                i_rx_event,
   input  logic                i_selected,
   output logic [K_DWIDTH-1:0] o_tx_data,
   output logic                o_tx_valid,
   output logic [K_AWIDTH-1:0] o_bus_addr,
   output logic [K_DWIDTH-1:0] o_bus_wdata,
   output logic                o_bus_wr,
   output logic                o_bus_rd,
   input  logic                i_bus_ack,
   input  logic [K_DWIDTH-1:0] i_bus_rdata,
   output logic                o_busy,
   output logic                o_err_ovr
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      WR_DATA = 3'd2,
      WR_BUS  = 3'd3,
      RD_BUS  = 3'd4,
      RD_DATA = 3'd5,
      HOLD    = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [K_DWIDTH-1:0] tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic [K_AWIDTH-1:0] addr_q, addr_d;
   logic [K_DWIDTH-1:0] wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                rd_q, rd_d;
   logic                busy_q, busy_d;
   logic                err_ovr_q, err_ovr_d;
   logic                ovr_q, ovr_d;
   logic                abort_q, abort_d;
   logic                desel_q, desel_d;
   logic                sel_q;
   logic                sel_rise;
   logic                ovr_set, abort_set, sticky_clr;

   assign sel_rise = i_selected & ~sel_q;

   // State and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         busy_q     <= 1'b0;
         err_ovr_q  <= 1'b0;
         ovr_q      <= 1'b0;
         abort_q    <= 1'b0;
         desel_q    <= 1'b0;
         sel_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         busy_q     <= busy_d;
         err_ovr_q  <= err_ovr_d;
         ovr_q      <= ovr_d;
         abort_q    <= abort_d;
         desel_q    <= desel_d;
         sel_q      <= i_selected;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      err_ovr_d  = 1'b0;
      desel_d    = desel_q;
      ovr_set    = 1'b0;
      abort_set  = 1'b0;
      sticky_clr = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (sel_rise) begin
               state_d    = CMD;
               tx_data_d  = K_DWIDTH'({abort_q, ovr_q});
               tx_valid_d = 1'b1;
               sticky_clr = 1'b1;
            end
         end

         CMD: begin
            if (!i_selected) begin
               state_d = IDLE;
            end else if (i_rx_event) begin
               addr_d = i_rx_data[K_AWIDTH-1:0];
               if (i_rx_data[K_DWIDTH-1]) begin
                  state_d = RD_BUS;
                  rd_d    = 1'b1;
                  desel_d = 1'b0;
               end else begin
                  state_d = WR_DATA;
               end
            end
         end

         WR_DATA: begin
            if (!i_selected) begin
               state_d = IDLE;
            end else if (i_rx_event) begin
               wdata_d = i_rx_data;
               wr_d    = 1'b1;
               desel_d = 1'b0;
               state_d = WR_BUS;
            end
         end

         WR_BUS: begin
            // The request stays up through a deselect; only ack retires it
            if (!i_selected) begin
               desel_d = 1'b1;
            end else if (i_rx_event) begin
               err_ovr_d = 1'b1;
               ovr_set   = 1'b1;
            end
            if (i_bus_ack) begin
               wr_d    = 1'b0;
               desel_d = 1'b0;
               if (!i_selected || desel_q) begin
                  state_d   = IDLE;
                  abort_set = 1'b1;
               end else begin
`ifdef SPI_BRIDGE_AUTOINC_EN
                  state_d = WR_DATA;
                  addr_d  = addr_q + K_AWIDTH'(1);
`else
                  state_d = HOLD;
`endif
               end
            end
         end

         RD_BUS: begin
            if (!i_selected) begin
               desel_d = 1'b1;
            end else if (i_rx_event) begin
               err_ovr_d = 1'b1;
               ovr_set   = 1'b1;
            end
            if (i_bus_ack) begin
               rd_d    = 1'b0;
               desel_d = 1'b0;
               if (!i_selected || desel_q) begin
                  state_d   = IDLE;
                  abort_set = 1'b1;
               end else begin
                  tx_data_d  = i_bus_rdata;
                  tx_valid_d = 1'b1;
                  state_d    = RD_DATA;
               end
            end
         end

         RD_DATA: begin
            // The dummy word that clocks read data out triggers the next read
            if (!i_selected) begin
               state_d = IDLE;
            end else if (i_rx_event) begin
`ifdef SPI_BRIDGE_AUTOINC_EN
               addr_d  = addr_q + K_AWIDTH'(1);
               rd_d    = 1'b1;
               desel_d = 1'b0;
               state_d = RD_BUS;
`else
               state_d = HOLD;
`endif
            end
         end

         HOLD: begin
            if (!i_selected) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
         end
      endcase

      // A set event in the same cycle as the status load wins over the clear
      ovr_d   = (ovr_q   & ~sticky_clr) | ovr_set;
      abort_d = (abort_q & ~sticky_clr) | abort_set;
      busy_d  = (state_d != IDLE);
   end

   assign o_tx_data   = tx_data_q;
   assign o_tx_valid  = tx_valid_q;
   assign o_bus_addr  = addr_q;
   assign o_bus_wdata = wdata_q;
   assign o_bus_wr    = wr_q;
   assign o_bus_rd    = rd_q;
   assign o_busy      = busy_q;
   assign o_err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge (honours SPI_BRIDGE_AUTOINC_EN if defined).
module tb_spi_reg_bridge;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 8;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [DW-1:0] i_rx_data;
   logic          i_rx_event;
   logic          i_selected;
   logic [DW-1:0] o_tx_data;
   logic          o_tx_valid;
   logic [AW-1:0] o_bus_addr;
   logic [DW-1:0] o_bus_wdata;
   logic          o_bus_wr;
   logic          o_bus_rd;
   logic          i_bus_ack;
   logic [DW-1:0] i_bus_rdata;
   logic          o_busy;
   logic          o_err_ovr;

   int n_cmp = 0;
   int n_err = 0;

   spi_reg_bridge #(.K_DWIDTH(DW), .K_AWIDTH(AW)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rx_data  (i_rx_data),
      .i_rx_event (i_rx_event),
      .i_selected (i_selected),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .o_bus_addr (o_bus_addr),
      .o_bus_wdata(o_bus_wdata),
      .o_bus_wr   (o_bus_wr),
      .o_bus_rd   (o_bus_rd),
      .i_bus_ack  (i_bus_ack),
      .i_bus_rdata(i_bus_rdata),
      .o_busy     (o_busy),
      .o_err_ovr  (o_err_ovr)
   );

   always #5 i_clk = ~i_clk;

   // Step to just after the next active edge
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_word(input logic [DW-1:0] w);
      i_rx_data  = w;
      i_rx_event = 1'b1;
      tick();
      i_rx_event = 1'b0;
      i_rx_data  = '0;
   endtask

   task automatic ack_with(input logic [DW-1:0] rdata);
      i_bus_ack   = 1'b1;
      i_bus_rdata = rdata;
      tick();
      i_bus_ack   = 1'b0;
      i_bus_rdata = '0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_rx_data = '0; i_rx_event = 1'b0; i_selected = 1'b0;
      i_bus_ack = 1'b0; i_bus_rdata = '0;
      tick(); tick();
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", o_busy); end
      n_cmp++; if (o_tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b exp 0", o_tx_valid); end
      n_cmp++; if ({o_bus_wr, o_bus_rd, o_err_ovr} !== 3'b000) begin n_err++; $display("FAIL rst_req: got %b exp 000", {o_bus_wr, o_bus_rd, o_err_ovr}); end
      n_cmp++; if (o_tx_data !== 16'h0000) begin n_err++; $display("FAIL rst_tx_data: got %h exp 0000", o_tx_data); end
      n_cmp++; if (o_bus_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %h exp 00", o_bus_addr); end
      i_rst_n = 1'b1;
      tick();
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b exp 0", o_busy); end
   endtask

   task automatic test_single_write();
      i_selected = 1'b1;
      tick();
      n_cmp++; if (o_tx_valid !== 1'b1) begin n_err++; $display("FAIL wr_status_valid: got %b exp 1", o_tx_valid); end
      n_cmp++; if (o_tx_data !== 16'h0000) begin n_err++; $display("FAIL wr_status_word: got %h exp 0000", o_tx_data); end
      n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b exp 1", o_busy); end
      tick();
      n_cmp++; if (o_tx_valid !== 1'b0) begin n_err++; $display("FAIL wr_status_pulse: got %b exp 0", o_tx_valid); end
      send_word(16'h0012);
      n_cmp++; if (o_bus_addr !== 8'h12) begin n_err++; $display("FAIL wr_addr: got %h exp 12", o_bus_addr); end
      n_cmp++; if (o_bus_wr !== 1'b0) begin n_err++; $display("FAIL wr_early: got %b exp 0", o_bus_wr); end
      tick();
      send_word(16'hBEEF);
      n_cmp++; if (o_bus_wr !== 1'b1) begin n_err++; $display("FAIL wr_req: got %b exp 1", o_bus_wr); end
      n_cmp++; if (o_bus_wdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_wdata: got %h exp BEEF", o_bus_wdata); end
      tick(); tick();
      n_cmp++; if (o_bus_wr !== 1'b1) begin n_err++; $display("FAIL wr_hold: got %b exp 1", o_bus_wr); end
      n_cmp++; if (o_bus_addr !== 8'h12) begin n_err++; $display("FAIL wr_addr_hold: got %h exp 12", o_bus_addr); end
      ack_with(16'h0000);
      n_cmp++; if (o_bus_wr !== 1'b0) begin n_err++; $display("FAIL wr_drop: got %b exp 0", o_bus_wr); end
      n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_after: got %b exp 1", o_busy); end
      i_selected = 1'b0;
      tick();
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL wr_idle: got %b exp 0", o_busy); end
      tick();
   endtask

   task automatic test_single_read();
      i_selected = 1'b1;
      tick();
      n_cmp++; if ({o_tx_valid, o_tx_data} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL rd_status: got %b/%h exp 1/0000", o_tx_valid, o_tx_data); end
      tick();
      send_word(16'h8034);
      n_cmp++; if (o_bus_rd !== 1'b1) begin n_err++; $display("FAIL rd_req: got %b exp 1", o_bus_rd); end
      n_cmp++; if (o_bus_addr !== 8'h34) begin n_err++; $display("FAIL rd_addr: got %h exp 34", o_bus_addr); end
      tick();
      n_cmp++; if (o_bus_rd !== 1'b1) begin n_err++; $display("FAIL rd_hold: got %b exp 1", o_bus_rd); end
      ack_with(16'hA5A5);
      n_cmp++; if (o_bus_rd !== 1'b0) begin n_err++; $display("FAIL rd_drop: got %b exp 0", o_bus_rd); end
      n_cmp++; if (o_tx_valid !== 1'b1) begin n_err++; $display("FAIL rd_tx_valid: got %b exp 1", o_tx_valid); end
      n_cmp++; if (o_tx_data !== 16'hA5A5) begin n_err++; $display("FAIL rd_tx_data: got %h exp A5A5", o_tx_data); end
      tick();
      n_cmp++; if (o_tx_valid !== 1'b0) begin n_err++; $display("FAIL rd_tx_pulse: got %b exp 0", o_tx_valid); end
      i_selected = 1'b0;
      tick();
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rd_idle: got %b exp 0", o_busy); end
      tick();
   endtask

   task automatic test_burst_read();
      logic [AW-1:0] exp_addr [4];
      logic [DW-1:0] rvals    [4];
      exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      rvals    = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      i_selected = 1'b1;
      tick();
      n_cmp++; if ({o_tx_valid, o_tx_data} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL br_status: got %b/%h exp 1/0000", o_tx_valid, o_tx_data); end
      tick();
      send_word(16'h80FE);
      n_cmp++; if ({o_bus_rd, o_bus_addr} !== {1'b1, 8'hFE}) begin n_err++; $display("FAIL br_req0: got %b/%h exp 1/FE", o_bus_rd, o_bus_addr); end
      ack_with(rvals[0]);
      n_cmp++; if ({o_tx_valid, o_tx_data} !== {1'b1, rvals[0]}) begin n_err++; $display("FAIL br_data0: got %b/%h exp 1/%h", o_tx_valid, o_tx_data, rvals[0]); end
      tick();
      for (int i = 1; i < 4; i++) begin
         send_word(16'h0000);
`ifdef SPI_BRIDGE_AUTOINC_EN
         n_cmp++; if ({o_bus_rd, o_bus_addr} !== {1'b1, exp_addr[i]}) begin n_err++; $display("FAIL br_req%0d: got %b/%h exp 1/%h", i, o_bus_rd, o_bus_addr, exp_addr[i]); end
         ack_with(rvals[i]);
         n_cmp++; if ({o_tx_valid, o_tx_data} !== {1'b1, rvals[i]}) begin n_err++; $display("FAIL br_data%0d: got %b/%h exp 1/%h", i, o_tx_valid, o_tx_data, rvals[i]); end
         tick();
`else
         n_cmp++; if ({o_bus_rd, o_tx_valid, o_busy} !== 3'b001) begin n_err++; $display("FAIL br_hold%0d: got rd/txv/busy %b exp 001", i, {o_bus_rd, o_tx_valid, o_busy}); end
         n_cmp++; if (o_bus_addr !== exp_addr[0]) begin n_err++; $display("FAIL br_noinc%0d: got %h exp %h", i, o_bus_addr, exp_addr[0]); end
         tick();
         n_cmp++; if (o_tx_valid !== 1'b0) begin n_err++; $display("FAIL br_hold_txv%0d: got %b exp 0", i, o_tx_valid); end
`endif
      end
      i_selected = 1'b0;
      tick();
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL br_idle: got %b exp 0", o_busy); end
      tick();
   endtask

   task automatic test_overrun();
      i_selected = 1'b1;
      tick();
      n_cmp++; if (o_tx_data !== 16'h0000) begin n_err++; $display("FAIL ov_status0: got %h exp 0000", o_tx_data); end
      tick();
      send_word(16'h0010);
      send_word(16'h1234);
      n_cmp++; if (o_err_ovr !== 1'b0) begin n_err++; $display("FAIL ov_none: got %b exp 0", o_err_ovr); end
      tick();
      send_word(16'h5678);
      n_cmp++; if (o_err_ovr !== 1'b1) begin n_err++; $display("FAIL ov_pulse: got %b exp 1", o_err_ovr); end
      n_cmp++; if ({o_bus_wr, o_bus_wdata} !== {1'b1, 16'h1234}) begin n_err++; $display("FAIL ov_kept: got %b/%h exp 1/1234", o_bus_wr, o_bus_wdata); end
      tick();
      n_cmp++; if (o_err_ovr !== 1'b0) begin n_err++; $display("FAIL ov_pulse_end: got %b exp 0", o_err_ovr); end
      ack_with(16'h0000);
      n_cmp++; if (o_bus_wr !== 1'b0) begin n_err++; $display("FAIL ov_drop: got %b exp 0", o_bus_wr); end
      i_selected = 1'b0;
      tick(); tick();
      i_selected = 1'b1;
      tick();
      n_cmp++; if ({o_tx_valid, o_tx_data} !== {1'b1, 16'h0001}) begin n_err++; $display("FAIL ov_status1: got %b/%h exp 1/0001", o_tx_valid, o_tx_data); end
      i_selected = 1'b0;
      tick(); tick();
      i_selected = 1'b1;
      tick();
      n_cmp++; if ({o_tx_valid, o_tx_data} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL ov_status2: got %b/%h exp 1/0000", o_tx_valid, o_tx_data); end
      i_selected = 1'b0;
      tick(); tick();
   endtask

   task automatic test_deselect_abort();
      i_selected = 1'b1;
      tick();
      tick();
      send_word(16'h8020);
      n_cmp++; if (o_bus_rd !== 1'b1) begin n_err++; $display("FAIL ab_req: got %b exp 1", o_bus_rd); end
      i_selected = 1'b0;
      tick(); tick();
      n_cmp++; if ({o_bus_rd, o_busy} !== 2'b11) begin n_err++; $display("FAIL ab_hold: got rd/busy %b exp 11", {o_bus_rd, o_busy}); end
      ack_with(16'hDEAD);
      n_cmp++; if ({o_bus_rd, o_tx_valid, o_busy} !== 3'b000) begin n_err++; $display("FAIL ab_done: got rd/txv/busy %b exp 000", {o_bus_rd, o_tx_valid, o_busy}); end
      tick();
      n_cmp++; if (o_tx_valid !== 1'b0) begin n_err++; $display("FAIL ab_no_tx: got %b exp 0", o_tx_valid); end
      i_selected = 1'b1;
      tick();
      n_cmp++; if ({o_tx_valid, o_tx_data} !== {1'b1, 16'h0002}) begin n_err++; $display("FAIL ab_status: got %b/%h exp 1/0002", o_tx_valid, o_tx_data); end
      i_selected = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      i_selected = 1'b1;
      tick(); tick();
      send_word(16'h0005);
      send_word(16'hCAFE);
      tick();
      send_word(16'h9999);
      n_cmp++; if ({o_bus_wr, o_err_ovr} !== 2'b11) begin n_err++; $display("FAIL rm_pre: got wr/ovr %b exp 11", {o_bus_wr, o_err_ovr}); end
      i_rst_n = 1'b0;
      #1;
      n_cmp++; if ({o_bus_wr, o_busy, o_tx_valid, o_err_ovr} !== 4'b0000) begin n_err++; $display("FAIL rm_async: got wr/busy/txv/ovr %b exp 0000", {o_bus_wr, o_busy, o_tx_valid, o_err_ovr}); end
      tick();
      i_selected = 1'b0;
      i_rst_n = 1'b1;
      tick(); tick();
      n_cmp++; if ({o_bus_wr, o_busy} !== 2'b00) begin n_err++; $display("FAIL rm_idle: got wr/busy %b exp 00", {o_bus_wr, o_busy}); end
      i_selected = 1'b1;
      tick();
      n_cmp++; if ({o_tx_valid, o_tx_data} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL rm_status: got %b/%h exp 1/0000", o_tx_valid, o_tx_data); end
      i_selected = 1'b0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_burst_read();
      test_overrun();
      test_deselect_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
